// File: rtl/vtiming_pkg.sv
// Shared types for the vtiming_ng raster timing engine.
// CNT_WIDTH/REP_WIDTH fix the struct layout and must match the top's CNT_W/REP_W.
package vtiming_pkg;

    localparam int CNT_WIDTH = 12;
    localparam int REP_WIDTH = 2;

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef logic [REP_WIDTH-1:0] rep_t;

    localparam rep_t DEF_REP = '0;

    typedef struct packed {
        cnt_t active;
        cnt_t sync_start;
        cnt_t sync_end;
        cnt_t total;
        logic pol;
        rep_t rep;
    } axis_cfg_t;

endpackage

// File: rtl/vtiming_axis.sv
// One raster axis: position counter with wrap, sync/active compare and
// pixel-repeat source counter. The *_nxt outputs preview the next position.
module vtiming_axis
    import vtiming_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_clr,
    input  logic      i_adv,
    input  axis_cfg_t i_cfg,
    output cnt_t      o_cnt,
    output cnt_t      o_src,
    output cnt_t      o_src_nxt,
    output logic      o_last,
    output logic      o_active,
    output logic      o_active_nxt,
    output logic      o_sync
);

    cnt_t r_cnt;
    cnt_t r_src;
    rep_t r_sub;

    cnt_t w_cnt_nxt;
    cnt_t w_src_nxt;
    rep_t w_sub_nxt;
    logic w_last;
    logic w_active_nxt;

    // A total of 0 or 1 pins the counter at 0; ">=" tolerates a shrunk total.
    always_comb begin
        w_last       = (i_cfg.total <= cnt_t'(1)) || (r_cnt >= i_cfg.total - cnt_t'(1));
        w_cnt_nxt    = w_last ? '0 : r_cnt + cnt_t'(1);
        w_active_nxt = (w_cnt_nxt < i_cfg.active);
        w_sub_nxt    = r_sub;
        w_src_nxt    = r_src;
        if (w_last) begin
            w_sub_nxt = '0;
            w_src_nxt = '0;
        end else if (w_active_nxt) begin
            if (r_sub >= i_cfg.rep) begin
                w_sub_nxt = '0;
                w_src_nxt = r_src + cnt_t'(1);
            end else begin
                w_sub_nxt = r_sub + rep_t'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
            r_sub <= DEF_REP;
            r_src <= '0;
        end else if (i_adv) begin
            r_cnt <= w_cnt_nxt;
            r_sub <= w_sub_nxt;
            r_src <= w_src_nxt;
        end
    end

    assign o_cnt        = r_cnt;
    assign o_src        = r_src;
    assign o_src_nxt    = w_src_nxt;
    assign o_last       = w_last;
    assign o_active     = (r_cnt < i_cfg.active);
    assign o_active_nxt = w_active_nxt;
    assign o_sync       = ((r_cnt >= i_cfg.sync_start) && (r_cnt < i_cfg.sync_end)) ~^ i_cfg.pol;

endmodule

// File: rtl/vtiming_ng.sv
// Two-axis raster timing engine with frame-boundary shadowed config,
// pixel-repeat scaling and a look-ahead line-fetch request.
module vtiming_ng
    import vtiming_pkg::*;
#(
    parameter int CNT_W = CNT_WIDTH,
    parameter int REP_W = REP_WIDTH,
    parameter int LEAD  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_h_active,
    input  logic [CNT_W-1:0] i_h_sync_start,
    input  logic [CNT_W-1:0] i_h_sync_end,
    input  logic [CNT_W-1:0] i_h_total,
    input  logic [CNT_W-1:0] i_v_active,
    input  logic [CNT_W-1:0] i_v_sync_start,
    input  logic [CNT_W-1:0] i_v_sync_end,
    input  logic [CNT_W-1:0] i_v_total,
    input  logic             i_h_sync_pol,
    input  logic             i_v_sync_pol,
    input  logic [REP_W-1:0] i_h_rep,
    input  logic [REP_W-1:0] i_v_rep,
    input  logic             i_cfg_update,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic [CNT_W-1:0] o_src_x,
    output logic [CNT_W-1:0] o_src_y,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_line_end,
    output logic             o_frame_end,
    output logic             o_fetch_req,
    output logic [CNT_W-1:0] o_fetch_line,
    output logic             o_cfg_busy
);

    localparam cnt_t LEAD_C = cnt_t'(LEAD);

    axis_cfg_t w_h_in, w_v_in;
    axis_cfg_t r_h_cfg, r_v_cfg;
    logic      r_armed;

    cnt_t w_h_cnt, w_h_src, w_h_src_nxt_unused;
    cnt_t w_v_cnt, w_v_src, w_v_src_nxt;
    logic w_h_last, w_h_active, w_h_active_nxt_unused, w_h_sync;
    logic w_v_last, w_v_active, w_v_active_nxt, w_v_sync;
    logic w_frame_last, w_load, w_fetch;

    cnt_t r_x, r_y, r_src_x, r_src_y, r_fetch_line;
    logic r_hs, r_vs, r_de, r_line_end, r_frame_end, r_fetch_req;

    always_comb begin
        w_h_in.active     = i_h_active;
        w_h_in.sync_start = i_h_sync_start;
        w_h_in.sync_end   = i_h_sync_end;
        w_h_in.total      = i_h_total;
        w_h_in.pol        = i_h_sync_pol;
        w_h_in.rep        = i_h_rep;
        w_v_in.active     = i_v_active;
        w_v_in.sync_start = i_v_sync_start;
        w_v_in.sync_end   = i_v_sync_end;
        w_v_in.total      = i_v_total;
        w_v_in.pol        = i_v_sync_pol;
        w_v_in.rep        = i_v_rep;
    end

    vtiming_axis u_h_axis (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        (!i_en),
        .i_adv        (i_en),
        .i_cfg        (r_h_cfg),
        .o_cnt        (w_h_cnt),
        .o_src        (w_h_src),
        .o_src_nxt    (w_h_src_nxt_unused),
        .o_last       (w_h_last),
        .o_active     (w_h_active),
        .o_active_nxt (w_h_active_nxt_unused),
        .o_sync       (w_h_sync)
    );

    vtiming_axis u_v_axis (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        (!i_en),
        .i_adv        (i_en && w_h_last),
        .i_cfg        (r_v_cfg),
        .o_cnt        (w_v_cnt),
        .o_src        (w_v_src),
        .o_src_nxt    (w_v_src_nxt),
        .o_last       (w_v_last),
        .o_active     (w_v_active),
        .o_active_nxt (w_v_active_nxt),
        .o_sync       (w_v_sync)
    );

    // Shadows track the inputs while idle; when running they swap only on the last pixel.
    assign w_frame_last = w_h_last && w_v_last;
    assign w_load       = !i_en || ((r_armed || i_cfg_update) && w_frame_last);
    assign w_fetch      = i_en && (r_h_cfg.active > LEAD_C)
                        && (w_h_cnt == r_h_cfg.active - LEAD_C)
                        && (w_v_last || (w_v_active_nxt && (w_v_src_nxt != w_v_src)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cfg      <= w_h_in;
            r_v_cfg      <= w_v_in;
            r_armed      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_hs         <= ~i_h_sync_pol;
            r_vs         <= ~i_v_sync_pol;
            r_de         <= 1'b0;
            r_line_end   <= 1'b0;
            r_frame_end  <= 1'b0;
            r_fetch_req  <= 1'b0;
            r_fetch_line <= '0;
        end else begin
            if (w_load) begin
                r_h_cfg <= w_h_in;
                r_v_cfg <= w_v_in;
            end
            r_armed     <= !w_load && (r_armed || i_cfg_update);
            r_x         <= i_en ? w_h_cnt : '0;
            r_y         <= i_en ? w_v_cnt : '0;
            r_src_x     <= i_en ? w_h_src : '0;
            r_src_y     <= i_en ? w_v_src : '0;
            r_hs        <= i_en ? w_h_sync : ~r_h_cfg.pol;
            r_vs        <= i_en ? w_v_sync : ~r_v_cfg.pol;
            r_de        <= i_en && w_h_active && w_v_active;
            r_line_end  <= i_en && w_h_last;
            r_frame_end <= i_en && w_frame_last;
            r_fetch_req <= w_fetch;
            if (w_fetch) begin
                r_fetch_line <= w_v_src_nxt;
            end
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_src_x      = r_src_x;
    assign o_src_y      = r_src_y;
    assign o_hs         = r_hs;
    assign o_vs         = r_vs;
    assign o_de         = r_de;
    assign o_line_end   = r_line_end;
    assign o_frame_end  = r_frame_end;
    assign o_fetch_req  = r_fetch_req;
    assign o_fetch_line = r_fetch_line;
    assign o_cfg_busy   = r_armed;

endmodule

// File: tb/tb_vtiming_ng.sv
// Directed bench for vtiming_ng: frame timing, scaling, fetch, shadowing,
// enable/reset behaviour and the degenerate h_total = 1 case.
module tb_vtiming_ng;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         i_reset, i_en, i_cfg_update;
    logic [W-1:0] i_h_active, i_h_sync_start, i_h_sync_end, i_h_total;
    logic [W-1:0] i_v_active, i_v_sync_start, i_v_sync_end, i_v_total;
    logic         i_h_sync_pol, i_v_sync_pol;
    logic [1:0]   i_h_rep, i_v_rep;
    logic [W-1:0] o_x, o_y, o_src_x, o_src_y, o_fetch_line;
    logic         o_hs, o_vs, o_de, o_line_end, o_frame_end, o_fetch_req, o_cfg_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vtiming_ng #(.CNT_W(W), .REP_W(2), .LEAD(2)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_en(i_en),
        .i_h_active(i_h_active), .i_h_sync_start(i_h_sync_start),
        .i_h_sync_end(i_h_sync_end), .i_h_total(i_h_total),
        .i_v_active(i_v_active), .i_v_sync_start(i_v_sync_start),
        .i_v_sync_end(i_v_sync_end), .i_v_total(i_v_total),
        .i_h_sync_pol(i_h_sync_pol), .i_v_sync_pol(i_v_sync_pol),
        .i_h_rep(i_h_rep), .i_v_rep(i_v_rep), .i_cfg_update(i_cfg_update),
        .o_x(o_x), .o_y(o_y), .o_src_x(o_src_x), .o_src_y(o_src_y),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
        .o_line_end(o_line_end), .o_frame_end(o_frame_end),
        .o_fetch_req(o_fetch_req), .o_fetch_line(o_fetch_line),
        .o_cfg_busy(o_cfg_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Idle one cycle (shadows reload), then start a fresh frame at the origin.
    task automatic restart();
        i_en = 1'b0;
        @(negedge clk);
        check("idle_de", o_de, 0);
        check("idle_x", o_x, 0);
        i_en = 1'b1;
    endtask

    // Frames of the 24x8 mode (active 16x4, hsync 18-19, vsync line 5, LEAD 2).
    task automatic run_frames(input int n, input int hr, input int vr);
        for (int k = 0; k < n; k++) begin
            int ex, ey, eline;
            logic efet;
            @(negedge clk);
            ex = k % 24;
            ey = (k / 24) % 8;
            efet = (ex == 14) && ((ey == 7) || ((ey + 1 < 4) && ((ey + 1) / (vr + 1) != ey / (vr + 1))));
            eline = (ey == 7) ? 0 : (ey + 1) / (vr + 1);
            check($sformatf("x k=%0d", k), o_x, ex);
            check($sformatf("y k=%0d", k), o_y, ey);
            check($sformatf("de %0d,%0d", ex, ey), o_de, (ex < 16 && ey < 4));
            check($sformatf("hs %0d,%0d", ex, ey), o_hs, (ex >= 18 && ex < 20));
            check($sformatf("vs %0d,%0d", ex, ey), o_vs, (ey == 5));
            check($sformatf("line_end %0d,%0d", ex, ey), o_line_end, (ex == 23));
            check($sformatf("frame_end %0d,%0d", ex, ey), o_frame_end, (ex == 23 && ey == 7));
            check($sformatf("src_x %0d,%0d", ex, ey), o_src_x, (ex < 16 ? ex : 15) / (hr + 1));
            check($sformatf("src_y %0d,%0d", ex, ey), o_src_y, (ey < 4 ? ey : 3) / (vr + 1));
            check($sformatf("fetch %0d,%0d", ex, ey), o_fetch_req, efet);
            if (efet) check($sformatf("fetch_line %0d,%0d", ex, ey), o_fetch_line, eline);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1; i_en = 1'b0; i_cfg_update = 1'b0;
        i_h_active = 16; i_h_sync_start = 18; i_h_sync_end = 20; i_h_total = 24;
        i_v_active = 4;  i_v_sync_start = 5;  i_v_sync_end = 6;  i_v_total = 8;
        i_h_sync_pol = 1'b1; i_v_sync_pol = 1'b1; i_h_rep = 0; i_v_rep = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", o_x, 0);
        check("rst_y", o_y, 0);
        check("rst_src_x", o_src_x, 0);
        check("rst_src_y", o_src_y, 0);
        check("rst_hs", o_hs, 0);
        check("rst_vs", o_vs, 0);
        check("rst_de", o_de, 0);
        check("rst_line_end", o_line_end, 0);
        check("rst_frame_end", o_frame_end, 0);
        check("rst_fetch", o_fetch_req, 0);
        check("rst_fetch_line", o_fetch_line, 0);
        check("rst_busy", o_cfg_busy, 0);
        i_reset = 1'b0;
        i_en = 1'b1;

        // Base mode over two frames: frame_end period of 192.
        run_frames(384, 0, 0);

        // 2x2 pixel repeat.
        i_h_rep = 1; i_v_rep = 1;
        restart();
        run_frames(192, 1, 1);

        // Mid-frame config update: old 24-pixel line kept until the frame ends.
        i_h_rep = 0; i_v_rep = 0;
        restart();
        for (int k = 0; k < 192; k++) begin
            @(negedge clk);
            check($sformatf("upd_x k=%0d", k), o_x, k % 24);
            if (k >= 51 && k < 191) check($sformatf("busy k=%0d", k), o_cfg_busy, 1);
            if (k == 50) begin
                check("busy_pre", o_cfg_busy, 0);
                i_h_total = 32;
                i_cfg_update = 1'b1;
            end
            if (k == 51) i_cfg_update = 1'b0;
        end
        check("busy_at_frame_end", o_cfg_busy, 0);
        check("frame_end_old", o_frame_end, 1);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            check($sformatf("new_x k=%0d", k), o_x, k % 32);
            check($sformatf("new_y k=%0d", k), o_y, k / 32);
            check($sformatf("new_line_end k=%0d", k), o_line_end, (k % 32) == 31);
        end

        // Enable dropped on line 2 (last sample was x=5, y=2).
        check("pre_drop_de", o_de, 1);
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dis_de", o_de, 0);
            check("dis_x", o_x, 0);
            check("dis_y", o_y, 0);
            check("dis_hs", o_hs, 0);
            check("dis_vs", o_vs, 0);
            check("dis_line_end", o_line_end, 0);
        end
        i_en = 1'b1;
        @(negedge clk);
        check("reen_x", o_x, 0);
        check("reen_y", o_y, 0);
        check("reen_de", o_de, 1);
        @(negedge clk);
        check("reen_x1", o_x, 1);

        // Reset mid-line with negative-going syncs.
        repeat (8) @(negedge clk);
        check("pre_rst_x", o_x, 9);
        i_h_sync_pol = 1'b0; i_v_sync_pol = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        check("mrst_hs", o_hs, 1);
        check("mrst_vs", o_vs, 1);
        check("mrst_de", o_de, 0);
        check("mrst_x", o_x, 0);
        check("mrst_y", o_y, 0);
        check("mrst_line_end", o_line_end, 0);
        check("mrst_frame_end", o_frame_end, 0);
        check("mrst_fetch", o_fetch_req, 0);
        check("mrst_busy", o_cfg_busy, 0);
        i_reset = 1'b0;
        @(negedge clk);
        check("post_rst_x", o_x, 0);
        check("post_rst_de", o_de, 1);
        check("post_rst_hs", o_hs, 1);
        repeat (18) @(negedge clk);
        check("neg_hs_x", o_x, 18);
        check("neg_hs", o_hs, 0);
        check("neg_vs", o_vs, 1);

        // Degenerate h_total = 1: h pinned, v steps every cycle.
        i_h_total = 1;
        restart();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("ht1_x k=%0d", k), o_x, 0);
            check($sformatf("ht1_y k=%0d", k), o_y, k % 8);
            check($sformatf("ht1_line_end k=%0d", k), o_line_end, 1);
            check($sformatf("ht1_frame_end k=%0d", k), o_frame_end, (k % 8) == 7);
            check($sformatf("ht1_de k=%0d", k), o_de, (k % 8) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vtiming_ng.md
Name: vtiming_ng

Overview:
- Parametrised next-generation raster timing engine for the Orion-NG video path.
- Replaces the pair of single-axis sync generators with one block. It counts both axes and shadows the timing registers so a new mode takes effect only at a frame boundary.
- Adds independent H/V pixel-repeat scaling and a line-fetch request with programmable lead, to prime the video memory line buffer.
- Sits between the video control register file (config inputs) and the pixel pipeline / line-buffer fetch logic.

Parameters:
- CNT_W, 12: width of all H/V timing values and counters.
- REP_W, 2: width of the repeat-factor fields. The repeat factor is field+1, so 1..4 for the default.
- LEAD, 8: number of pixel clocks before the end of the active line at which o_fetch_req fires. Must be < minimum h_active.

Ports:
- i_clk  in  1  pixel clock; the only clock.
- i_reset  in  1  synchronous reset, active-high.
- i_en  in  1  timing enable. When low, the counters are held at the origin.
- i_h_active, i_h_sync_start, i_h_sync_end, i_h_total  in  CNT_W each  horizontal timing, in pixels.
- i_v_active, i_v_sync_start, i_v_sync_end, i_v_total  in  CNT_W each  vertical timing, in lines.
- i_h_sync_pol, i_v_sync_pol  in  1 each  1 = positive-going sync.
- i_h_rep, i_v_rep  in  REP_W each  repeat factor minus 1.
- i_cfg_update  in  1  one-cycle strobe: arm a shadow load.
- o_x, o_y  out  CNT_W each  raster position.
- o_src_x, o_src_y  out  CNT_W each  scaled source coordinates.
- o_hs, o_vs, o_de  out  1 each  sync outputs and data enable.
- o_line_end, o_frame_end  out  1 each  single-cycle pulses.
- o_fetch_req  out  1  single-cycle pulse requesting a line fetch.
- o_fetch_line  out  CNT_W  source line to fetch.
- o_cfg_busy  out  1  a shadow load is armed but not yet applied.

Behaviour:
- **Reset:**
  - Counters, src coordinates and o_fetch_line go to 0.
  - o_de, o_line_end, o_frame_end, o_fetch_req and o_cfg_busy go to 0.
  - o_hs and o_vs go to the inactive level, i.e. ~pol.
  - Shadow registers load directly from the inputs.
- **Shadow registers:**
  - i_cfg_update sets the armed flag (o_cfg_busy = 1).
  - The shadow load happens on the last pixel of the frame (h == total-1 and v == total-1), or immediately while i_en = 0. The armed flag clears in the same cycle.
  - If i_cfg_update coincides with the load cycle, the load uses the current inputs and the flag clears.
- **Counters:**
  - h increments every cycle while i_en = 1.
  - h wraps to 0 when h >= h_total-1 (">=" guards against a shrunk config).
  - v increments on h wrap and wraps to 0 when v >= v_total-1.
  - A total of 0 or 1 behaves as 1: the counter is held at 0.
- **i_en:**
  - While low: h and v are held at 0, o_de = 0, syncs are inactive, no pulses.
  - When raised: the frame starts at (0,0) on the next cycle.
- **Outputs:** all registered, with one cycle of latency from the counter state.
  - o_de = (h < h_active) and (v < v_active).
  - o_hs = (sync_start <= h < sync_end) XNOR pol; o_vs likewise on v.
  - o_line_end pulses on h wrap.
  - o_frame_end pulses on the h wrap that also wraps v.
- **Scaling:**
  - A sub-counter per axis counts 0..rep.
  - src_x resets to 0 on h wrap. Within the active region, src_x increments each time the sub-counter wraps.
  - src_y works the same way, on line granularity. It resets at frame wrap.
  - Outside the active region, src values are held at their last value.
- **Fetch:**
  - o_fetch_req pulses at h == h_active-LEAD, for the line v+1, or for line 0 when v == v_total-1.
  - It fires only if that next line is active and its src_y differs from the current src_y, or if the next line is line 0.
  - o_fetch_line = next src_y, valid with the pulse.
  - If h_active <= LEAD, no fetch is issued.

Decomposition:
- Shared package vtiming_pkg:
  - typedef cnt_t (logic [CNT_W-1:0]) and rep_t.
  - struct axis_cfg_t {active, sync_start, sync_end, total, pol, rep}.
  - constant DEF_REP = 0.
- One sub-module, vtiming_axis: counter, wrap, sync and active compare, repeat sub-counter. It is instantiated twice (H and V, the V instance enabled by the H wrap).
- Fetch and shadow logic live in the top.

Test Plan:
- Config h 16/18/20/24, v 4/5/6/8, pol 1, rep 0, LEAD 2 → o_de high on 16 of 24 cycles for lines 0-3. o_hs high at h = 18-19. o_vs high on lines 5. o_frame_end pulses every 192 cycles.
- Same config with i_h_rep = 1, i_v_rep = 1 → src_x = 0,0,1,1,...,7,7. src_y = 0 for lines 0-1 and 1 for lines 2-3. o_fetch_req pulses at h = 14 on lines 1 and 7 only, with o_fetch_line = 1 and 0 respectively.
- Mid-frame i_cfg_update with h_total = 32 → o_cfg_busy = 1 until the frame_end cycle, and the old period of 24 is kept. The next frame's line period is 32.
- i_en dropped at v = 2 → outputs go inactive one cycle later. On re-enable, o_x = 0 and o_y = 0, and o_de is high on the following cycle.
- i_reset asserted mid-line with pol = 0 → next cycle o_hs = 1, o_vs = 1, o_de = 0, o_x = 0, o_y = 0, no pulses.
- h_total = 1 → h stays at 0, and v increments every cycle.
